// File: rtl/mrelbp_lut_pkg.sv
// Shared constants and types for the writable MRELBP N_i weight table.
// Consumed by lut_ni_loader and its bench.
package mrelbp_lut_pkg;

  localparam int LUT_DATA_W = 24;
  localparam int LUT_DEPTH  = 256;
  localparam int LUT_ADDR_W = 8;

  typedef logic [LUT_DATA_W-1:0] lut_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/lut_ram_sp.sv
// Weight storage: one synchronous write port and one asynchronous read port.
// No reset on the array so it maps onto distributed or block RAM.
module lut_ram_sp #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/lut_ni_loader.sv
// Streams DEPTH weights into the N_i table, then serves gated reads to the weighting stage.
// Optional running checksum of accepted words: define LUT_NI_LOADER_CHECKSUM_EN.
module lut_ni_loader
  import mrelbp_lut_pkg::*;
#(
  parameter int DATA_W = LUT_DATA_W,
  parameter int DEPTH  = LUT_DEPTH,
  parameter int ADDR_W = LUT_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_checksum
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we;
  logic              start_accept;
  logic [DATA_W-1:0] ram_rd_data;

  // A start pulse only counts outside LOAD; mid-load pulses are ignored.
  assign start_accept = i_start && (state_q != LOAD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we         = 1'b0;
    o_wr_ready = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_accept) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        o_wr_ready = 1'b1;
        o_busy     = 1'b1;
        if (i_wr_valid) begin
          we    = 1'b1;
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        o_done = 1'b1;
        if (start_accept) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  lut_ram_sp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_we      (we),
    .i_wr_addr (cnt_q),
    .i_wr_data (i_wr_data),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (ram_rd_data)
  );

  // Partially loaded tables must never reach the weighting stage.
  assign o_rd_data = o_done ? ram_rd_data : '0;

`ifdef LUT_NI_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  always_comb begin
    checksum_d = checksum_q;
    if (start_accept) begin
      checksum_d = '0;
    end else if (we) begin
      checksum_d = checksum_q + i_wr_data;
    end
  end

  assign o_checksum = checksum_q;
`else
  assign o_checksum = '0;
`endif

endmodule
